// File: rtl/pkg_aes.sv
// Shared AES constants and types: forward S-box, round constants, key-expansion FSM state.
package pkg_aes;

  localparam int KEY_W = 256;
  localparam int RK_W  = 128;
  localparam int N_RK  = 15;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Entry 0 is never selected: word 8 is the first to use a round constant.
  localparam logic [7:0] RCON [8] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT0,
    ST_EMIT1,
    ST_EXPAND
  } ke_state_e;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/mod_subWord.sv
// Combinational SubWord: four parallel forward S-box lookups on a 32-bit word.
module mod_subWord
  import pkg_aes::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_out[8*b +: 8] = SBOX[word_in[8*b +: 8]];
  end

endmodule

// File: rtl/mod_keyexpand.sv
// AES-256 key expansion: emits 15 round keys, one 128-bit write strobe each, one word per cycle.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for start_keyExp; key window holds last expansion
// ST_EMIT0   | writing round key 0 (cipher key words 0..3)
// ST_EMIT1   | writing round key 1 (cipher key words 4..7)
// ST_EXPAND  | computing word i per cycle, writing every fourth word
module mod_keyexpand
  import pkg_aes::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_keyExp,
  input  logic [KEY_W-1:0] inp_keyExp,
  output logic [RK_W-1:0]  outp_keyExp,
  output logic             wrEn_keyExp,
  output logic             busy_keyExp,
  output logic             done_keyExp
);

  localparam logic [5:0] I_FIRST = 6'd8;
  localparam logic [5:0] I_LAST  = 6'd59;

  ke_state_e        state_q, state_d;
  logic [5:0]       i_q, i_d;
  logic [31:0]      win_q [8];
  logic [31:0]      win_d [8];
  logic [RK_W-1:0]  outp_q, outp_d;
  logic             wren_q, wren_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [31:0]      sub_in, sub_out, rcon_word, t_word, new_word;

  // i%8==4 takes SubWord alone; i%8==0 takes SubWord(RotWord) plus the round constant.
  assign sub_in    = i_q[2] ? win_q[7] : rot_word(win_q[7]);
  assign rcon_word = {RCON[i_q[5:3]], 24'h0};

  mod_subWord u_subword (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  always_comb begin
    if (i_q[1:0] != 2'd0)
      t_word = win_q[7];
    else if (i_q[2])
      t_word = sub_out;
    else
      t_word = sub_out ^ rcon_word;
  end

  assign new_word = win_q[0] ^ t_word;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    win_d   = win_q;
    outp_d  = outp_q;
    wren_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_keyExp) begin
          for (int j = 0; j < 8; j++)
            win_d[j] = inp_keyExp[KEY_W-1-32*j -: 32];
          i_d     = I_FIRST;
          busy_d  = 1'b1;
          state_d = ST_EMIT0;
        end
      end

      ST_EMIT0: begin
        outp_d  = {win_q[0], win_q[1], win_q[2], win_q[3]};
        wren_d  = 1'b1;
        state_d = ST_EMIT1;
      end

      ST_EMIT1: begin
        outp_d  = {win_q[4], win_q[5], win_q[6], win_q[7]};
        wren_d  = 1'b1;
        state_d = ST_EXPAND;
      end

      ST_EXPAND: begin
        for (int j = 0; j < 7; j++)
          win_d[j] = win_q[j+1];
        win_d[7] = new_word;
        if (i_q[1:0] == 2'd3) begin
          outp_d = {win_q[5], win_q[6], win_q[7], new_word};
          wren_d = 1'b1;
        end
        // i stops at 59 rather than stepping out of its 8..59 range.
        if (i_q == I_LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          i_d = i_q + 6'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      win_q   <= '{default: '0};
      outp_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      win_q   <= win_d;
      outp_q  <= outp_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign outp_keyExp = outp_q;
  assign wrEn_keyExp = wren_q;
  assign busy_keyExp = busy_q;
  assign done_keyExp = done_q;

endmodule

// File: tb/tb_mod_keyexpand.sv
// Self-checking bench for mod_keyexpand against an array-based FIPS-197 key schedule model.
module tb_mod_keyexpand;

  logic         clk;
  logic         resetn;
  logic         start_keyExp;
  logic [255:0] inp_keyExp;
  logic [127:0] outp_keyExp;
  logic         wrEn_keyExp;
  logic         busy_keyExp;
  logic         done_keyExp;

  mod_keyexpand dut (
    .clk          (clk),
    .resetn       (resetn),
    .start_keyExp (start_keyExp),
    .inp_keyExp   (inp_keyExp),
    .outp_keyExp  (outp_keyExp),
    .wrEn_keyExp  (wrEn_keyExp),
    .busy_keyExp  (busy_keyExp),
    .done_keyExp  (done_keyExp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] FIPS_KEY =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  int           total = 0;
  int           bad   = 0;
  logic [7:0]   sb [256];
  logic [127:0] exp_rk [15];
  logic [127:0] got_rk [16];
  logic [127:0] last_outp;
  int           strobes;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // S-box derived from GF(2^8) inversion plus the affine map, independent of the RTL table.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] v);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sb[v[8*b +: 8]];
    return r;
  endfunction

  task automatic build_ref(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = sub_w(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int k = 0; k < 15; k++) exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_outp"}, outp_keyExp, 128'h0);
    check_val({tag, "_wren"}, 128'(wrEn_keyExp), 128'h0);
    check_val({tag, "_busy"}, 128'(busy_keyExp), 128'h0);
    check_val({tag, "_done"}, 128'(done_keyExp), 128'h0);
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      check_val("idle_wren", 128'(wrEn_keyExp), 128'h0);
      check_val("idle_busy", 128'(busy_keyExp), 128'h0);
      check_val("idle_done", 128'(done_keyExp), 128'h0);
      check_val("idle_hold", outp_keyExp, last_outp);
    end
  endtask

  // Called #1 after an edge; the next edge is E0. abort_at>0 pulls reset after that edge.
  task automatic run_key(input logic [255:0] key, input bit hold, input int abort_at);
    bit exp_wr;
    int k;
    build_ref(key);
    start_keyExp = 1'b1;
    inp_keyExp   = key;
    @(posedge clk); #1;
    if (!hold) start_keyExp = 1'b0;
    inp_keyExp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    check_val("e0_busy", 128'(busy_keyExp), 128'h1);
    check_val("e0_wren", 128'(wrEn_keyExp), 128'h0);
    strobes = 0;
    for (int n = 1; n <= 54; n++) begin
      @(posedge clk); #1;
      exp_wr = (n <= 2) || (n >= 6 && (n + 2) % 4 == 0);
      k      = (n <= 2) ? n - 1 : (n + 2) / 4;
      check_val("wren", 128'(wrEn_keyExp), 128'(exp_wr));
      if (wrEn_keyExp) begin
        if (strobes < 16) got_rk[strobes] = outp_keyExp;
        strobes++;
      end
      if (exp_wr) begin
        check_val($sformatf("rk%0d", k), outp_keyExp, exp_rk[k]);
        last_outp = exp_rk[k];
      end else begin
        check_val("hold", outp_keyExp, last_outp);
      end
      check_val("done", 128'(done_keyExp), 128'(n == 54));
      check_val("busy", 128'(busy_keyExp), 128'(n < 54));
      if (n == abort_at) begin
        resetn = 1'b0;
        #1;
        check_zero("abort");
        for (int c = 0; c < 3; c++) begin
          @(posedge clk); #1;
          check_zero("in_reset");
        end
        resetn    = 1'b1;
        last_outp = '0;
        start_keyExp = 1'b0;
        return;
      end
    end
    check_val("strobe_cnt", 128'(strobes), 128'd15);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] rk;
    resetn       = 1'b0;
    start_keyExp = 1'b0;
    inp_keyExp   = '0;
    last_outp    = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    resetn = 1'b1;
    idle_cycles(2);

    run_key(FIPS_KEY, 1'b0, 0);
    check_val("fips_e1", got_rk[0], 128'h603deb1015ca71be2b73aef0857d7781);
    check_val("fips_e2", got_rk[1], 128'h1f352c073b6108d72d9810a30914dff4);
    check_val("fips_e6", got_rk[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    check_val("fips_e10", got_rk[3], 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
    check_val("fips_e54", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
    idle_cycles(3);

    for (int r = 0; r < 4; r++) begin
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_key(rk, 1'b0, 0);
      idle_cycles($urandom_range(1, 4));
    end

    run_key(256'h0, 1'b0, 0);
    check_val("zero_rk2", got_rk[2], 128'h62636363626363636263636362636363);
    idle_cycles(2);

    // Held start: ignored while busy, second run accepted at E55.
    run_key(FIPS_KEY, 1'b1, 0);
    run_key(FIPS_KEY, 1'b0, 0);
    check_val("held_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
    idle_cycles(2);

    rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_key(rk, 1'b0, 20);
    idle_cycles(5);
    run_key(FIPS_KEY, 1'b0, 0);
    check_val("rerun_e6", got_rk[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    check_val("rerun_e54", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Back-to-back: new key accepted at E55, first write at E56.
    rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_key(rk, 1'b0, 0);
    check_val("b2b_first", got_rk[0], rk[255:128]);
    idle_cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
